// File: rtl/countdown_timer_60_pkg.sv
// Shared timer definitions: FSM state encodings, digit widths, default digit limits and clamp helpers.
// Used by countdown_timer_60 (optional AUTO_RELOAD_EN build) and its sibling up-timer.
package countdown_timer_60_pkg;

    localparam int LOW_W        = 4;
    localparam int HIGH_W       = 3;
    localparam int LOW_MAX_DEF  = 9;
    localparam int HIGH_MAX_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    function automatic logic [LOW_W-1:0] clamp_low(input logic [LOW_W-1:0] v,
                                                    input logic [LOW_W-1:0] m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [HIGH_W-1:0] clamp_high(input logic [HIGH_W-1:0] v,
                                                      input logic [HIGH_W-1:0] m);
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/countdown_timer_60_bcd_digit_down.sv
// One loadable down-counting BCD digit; wraps 0 -> MAX on a decrement and flags the borrow.
module bcd_digit_down #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = W'(9)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_borrow
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec) begin
            r_value <= (r_value == '0) ? MAX : (r_value - W'(1));
        end
    end

    assign o_value  = r_value;
    assign o_borrow = i_dec && (r_value == '0);

endmodule

// File: rtl/countdown_timer_60.sv
// Loadable mod-60 BCD countdown timer with run/pause control and a one-cycle done pulse at 00.
// Define AUTO_RELOAD_EN to keep running after expiry and reload the stored preset on the next tick.
module countdown_timer_60
    import countdown_timer_60_pkg::*;
#(
    parameter int LOW_MAX  = LOW_MAX_DEF,
    parameter int HIGH_MAX = HIGH_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [LOW_W-1:0]  preset_low,
    input  logic [HIGH_W-1:0] preset_high,
    input  logic              start,
    input  logic              pause,
    output logic [LOW_W-1:0]  low_digit,
    output logic [HIGH_W-1:0] high_digit,
    output logic              running,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam logic [LOW_W-1:0]  LOW_MAX_V  = LOW_W'(LOW_MAX);
    localparam logic [HIGH_W-1:0] HIGH_MAX_V = HIGH_W'(HIGH_MAX);

    timer_state_t      r_state;
    logic [LOW_W-1:0]  r_preset_low;
    logic [HIGH_W-1:0] r_preset_high;
    logic              r_running;
    logic              r_done;

    logic [LOW_W-1:0]  w_low;
    logic [HIGH_W-1:0] w_high;
    logic [LOW_W-1:0]  w_clamp_low;
    logic [HIGH_W-1:0] w_clamp_high;
    logic [LOW_W-1:0]  w_load_low;
    logic [HIGH_W-1:0] w_load_high;
    logic              w_zero;
    logic              w_expire;
    logic              w_preset_zero;
    logic              w_load_ok;
    logic              w_tick;
    logic              w_dec_low;
    logic              w_low_borrow;
    logic              w_high_borrow;
    logic              w_reload;
    logic              w_digit_load;

    assign w_clamp_low   = clamp_low(preset_low, LOW_MAX_V);
    assign w_clamp_high  = clamp_high(preset_high, HIGH_MAX_V);
    assign w_zero        = (w_low == '0) && (w_high == '0);
    assign w_expire      = (w_low == LOW_W'(1)) && (w_high == '0);
    assign w_preset_zero = (r_preset_low == '0) && (r_preset_high == '0);

    // A tick only counts in RUN and when the same cycle is not also pausing.
    assign w_load_ok = load && (r_state != ST_RUN);
    assign w_tick    = (r_state == ST_RUN) && enable && !pause;
    assign w_dec_low = w_tick && !w_zero;

`ifdef AUTO_RELOAD_EN
    assign w_reload = w_tick && w_zero && !w_preset_zero;
`else
    assign w_reload = 1'b0;
`endif

    assign w_digit_load = w_load_ok || w_reload;
    assign w_load_low   = w_load_ok ? w_clamp_low  : r_preset_low;
    assign w_load_high  = w_load_ok ? w_clamp_high : r_preset_high;

    bcd_digit_down #(.W(LOW_W), .MAX(LOW_MAX_V)) u_low (
        .clk        (clk),
        .reset      (reset),
        .i_dec      (w_dec_low),
        .i_load     (w_digit_load),
        .i_load_val (w_load_low),
        .o_value    (w_low),
        .o_borrow   (w_low_borrow)
    );

    bcd_digit_down #(.W(HIGH_W), .MAX(HIGH_MAX_V)) u_high (
        .clk        (clk),
        .reset      (reset),
        .i_dec      (w_low_borrow),
        .i_load     (w_digit_load),
        .i_load_val (w_load_high),
        .o_value    (w_high),
        .o_borrow   (w_high_borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_preset_low  <= '0;
            r_preset_high <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (load) begin
                        r_preset_low  <= w_clamp_low;
                        r_preset_high <= w_clamp_high;
                        r_state       <= ST_IDLE;
                        r_running     <= 1'b0;
                    end else if (start && !pause && !w_zero) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (enable) begin
                        if (w_expire) begin
                            r_done <= 1'b1;
`ifndef AUTO_RELOAD_EN
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
`endif
                        end else if (w_zero && !w_reload) begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        r_preset_low  <= w_clamp_low;
                        r_preset_high <= w_clamp_high;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign low_digit  = w_low;
    assign high_digit = w_high;
    assign running    = r_running;
    assign done       = r_done;
    assign dbg_state  = r_state;

    logic w_unused;
    assign w_unused = w_high_borrow;

endmodule

// File: tb/tb_countdown_timer_60.sv
// Bench for countdown_timer_60: directed scenarios plus random control traffic, scored against a seconds-count model.
module tb_countdown_timer_60;
    import countdown_timer_60_pkg::*;

    localparam int W = 11;
`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [3:0] preset_low = '0;
    logic [2:0] preset_high = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] low_digit;
    logic [2:0] high_digit;
    logic       running;
    logic       done;
    logic [1:0] dbg_state;

    countdown_timer_60 dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .preset_low  (preset_low),
        .preset_high (preset_high),
        .start       (start),
        .pause       (pause),
        .low_digit   (low_digit),
        .high_digit  (high_digit),
        .running     (running),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: the count is kept as plain seconds 0..59
    int           m_cnt = 0;
    int           m_preset = 0;
    timer_state_t m_state = ST_IDLE;
    bit           m_done = 1'b0;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cycle = 0;

    function automatic void model_load(input int ph, input int pl);
        m_preset = ((ph > 5) ? 5 : ph) * 10 + ((pl > 9) ? 9 : pl);
        m_cnt    = m_preset;
        m_state  = ST_IDLE;
    endfunction

    function automatic void model_step(input bit rst, input bit en, input bit ld,
                                       input bit st, input bit pa, input int ph, input int pl);
        if (rst) begin
            m_cnt = 0; m_preset = 0; m_state = ST_IDLE; m_done = 1'b0;
            return;
        end
        m_done = 1'b0;
        case (m_state)
            ST_IDLE, ST_PAUSE: begin
                if (ld) model_load(ph, pl);
                else if (st && !pa && m_cnt != 0) m_state = ST_RUN;
            end
            ST_RUN: begin
                if (pa) m_state = ST_PAUSE;
                else if (en) begin
                    if (m_cnt == 1) begin
                        m_cnt = 0;
                        m_done = 1'b1;
                        if (!AUTO) m_state = ST_DONE;
                    end else if (m_cnt == 0) begin
                        if (AUTO && m_preset != 0) m_cnt = m_preset;
                        else m_state = ST_DONE;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
            ST_DONE: if (ld) model_load(ph, pl);
            default: m_state = ST_IDLE;
        endcase
    endfunction

    function automatic logic [W-1:0] model_pack();
        logic [3:0] el;
        logic [2:0] eh;
        el = 4'(m_cnt % 10);
        eh = 3'(m_cnt / 10);
        return {el, eh, (m_state == ST_RUN), m_done, 2'(m_state)};
    endfunction

    // driver tasks
    task automatic drive(input bit rst, input bit en, input bit ld, input bit st,
                         input bit pa, input int ph, input int pl);
        reset = rst; enable = en; load = ld; start = st; pause = pa;
        preset_high = 3'(ph); preset_low = 4'(pl);
        model_step(rst, en, ld, st, pa, ph, pl);
        @(posedge clk);
        exp_q.push_back(model_pack());
        #1;
    endtask

    task automatic idle();                      drive(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic tick();                      drive(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic do_start();                  drive(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_pause();                  drive(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_load(input int h, input int l); drive(0, 0, 1, 0, 0, h, l); endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        #2;
        cycle++;
        if (exp_q.size() > 0) begin
            got = {low_digit, high_digit, running, done, dbg_state};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL outputs cycle=%0d got low=%0d high=%0d run=%0b done=%0b st=%0d exp low=%0d high=%0d run=%0b done=%0b st=%0d",
                         cycle, got[10:7], got[6:4], got[3], got[2], got[1:0],
                         exp[10:7], exp[6:4], exp[3], exp[2], exp[1:0]);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 5, 9);

        // full 59 -> 00 countdown, ticks spaced by idle cycles
        do_load(5, 9);
        do_start();
        for (int i = 0; i < 60; i++) begin
            tick();
            idle();
        end
        tick();
        tick();

        // start at 00 is ignored
        do_load(0, 0);
        do_start();
        repeat (3) tick();

        // clamping, then load during RUN ignored
        do_load(7, 12);
        do_start();
        repeat (25) tick();
        do_load(1, 1);
        tick();
        do_pause();

        // pause wins over start; ticks ignored while paused
        do_load(1, 0);
        do_start();
        tick();
        drive(0, 0, 0, 1, 1, 0, 0);
        repeat (3) tick();
        do_start();
        tick();

        // reset mid-run aborts
        do_load(0, 2);
        do_start();
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        idle();

        // expiry behaviour (one-shot or auto-reload depending on build)
        do_load(0, 2);
        do_start();
        repeat (6) tick();
        do_pause();

        // random control traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0),
                  ($urandom_range(1) == 1),
                  ($urandom_range(19) == 0),
                  ($urandom_range(9) == 0),
                  ($urandom_range(24) == 0),
                  int'($urandom_range(7)),
                  int'($urandom_range(15)));
        end
        idle();

        repeat (3) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
